// File: rtl/msm_stream_loader_if.sv
// Word-serial stream bundle between the MSM loader and its upstream/downstream environment.
// master = environment (feeds words, accepts results); slave = loader.
interface msm_stream_loader_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/msm_stream_loader.sv
// Stream front end for msm_naive: assembles G/x banks from words, runs the engine,
// then serialises R = (Rx, Ry) back out as words.
module msm_stream_loader #(
  parameter int unsigned LENGTH       = 1000,
  parameter int unsigned P_WIDTH      = 256,
  parameter int unsigned SCALAR_WIDTH = 256,
  parameter int unsigned WORD_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  Reset,
  msm_stream_loader_if.slave                    io,
  // Each point is packed {x, y} with x in the upper half.
  output logic [LENGTH-1:0][2*P_WIDTH-1:0]      G,
  output logic [LENGTH-1:0][SCALAR_WIDTH-1:0]   x,
  output logic                                  msm_reset,
  input  logic                                  msm_done,
  input  logic [P_WIDTH-1:0]                    msm_Rx,
  input  logic [P_WIDTH-1:0]                    msm_Ry,
  output logic                                  busy
);

  localparam int unsigned PW   = P_WIDTH / WORD_WIDTH;
  localparam int unsigned SW   = SCALAR_WIDTH / WORD_WIDTH;
  localparam int unsigned WPE  = 2 * PW + SW;
  localparam int unsigned OUTW = 2 * PW;
  localparam int unsigned WCW  = $clog2(WPE);
  localparam int unsigned ECW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned OCW  = $clog2(OUTW);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [WCW-1:0]          wcnt_q;
  logic [ECW-1:0]          ecnt_q;
  logic [OCW-1:0]          ocnt_q;
  logic                    wait_armed_q;
  logic [2*P_WIDTH-1:0]    res_q;
  logic [WORD_WIDTH-1:0]   bank_q [LENGTH][WPE];

  logic in_fire;
  logic out_fire;
  logic last_in;
  logic last_out;
  logic capture;

  assign in_fire  = (state_q == LOAD) && io.in_valid;
  assign out_fire = (state_q == SEND) && io.out_ready;
  assign last_in  = in_fire && (wcnt_q == WCW'(WPE - 1)) && (ecnt_q == ECW'(LENGTH - 1));
  assign last_out = out_fire && (ocnt_q == OCW'(OUTW - 1));
  // The first WAIT cycle may still see Done from the previous run.
  assign capture  = (state_q == WAIT) && wait_armed_q && msm_done;

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_in)  state_d = KICK;
      KICK:                  state_d = WAIT;
      WAIT:    if (capture)  state_d = SEND;
      SEND:    if (last_out) state_d = LOAD;
      default:               state_d = LOAD;
    endcase
  end

  // Output decode, purely from state and result counter.
  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_last  = 1'b0;
    msm_reset    = 1'b1;
    busy         = 1'b1;
    case (state_q)
      LOAD: begin
        io.in_ready = 1'b1;
        busy        = 1'b0;
      end
      KICK: ;
      WAIT: msm_reset = 1'b0;
      SEND: begin
        msm_reset    = 1'b0;
        io.out_valid = 1'b1;
        io.out_last  = (ocnt_q == OCW'(OUTW - 1));
      end
      default: ;
    endcase
  end

  assign io.out_data = res_q[WORD_WIDTH-1:0];

  // Counters and result shift register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wcnt_q       <= '0;
      ecnt_q       <= '0;
      ocnt_q       <= '0;
      wait_armed_q <= 1'b0;
      res_q        <= '0;
    end else begin
      wait_armed_q <= (state_q == WAIT);
      if (in_fire) begin
        if (wcnt_q == WCW'(WPE - 1)) begin
          wcnt_q <= '0;
          ecnt_q <= last_in ? '0 : ecnt_q + ECW'(1);
        end else begin
          wcnt_q <= wcnt_q + WCW'(1);
        end
      end
      if (capture) begin
        res_q <= {msm_Ry, msm_Rx};
      end else if (out_fire) begin
        res_q <= {WORD_WIDTH'(0), res_q[2*P_WIDTH-1:WORD_WIDTH]};
      end
      if (out_fire) begin
        ocnt_q <= last_out ? '0 : ocnt_q + OCW'(1);
      end
    end
  end

  // Bank is not reset: every slot is rewritten by the next full load.
  always_ff @(posedge clk) begin
    if (in_fire) bank_q[ecnt_q][wcnt_q] <= io.in_data;
  end

  for (genvar e = 0; e < LENGTH; e++) begin : g_elem
    for (genvar k = 0; k < PW; k++) begin : g_pw
      assign G[e][P_WIDTH + k*WORD_WIDTH +: WORD_WIDTH] = bank_q[e][k];
      assign G[e][k*WORD_WIDTH +: WORD_WIDTH]           = bank_q[e][PW + k];
    end
    for (genvar k = 0; k < SW; k++) begin : g_sw
      assign x[e][k*WORD_WIDTH +: WORD_WIDTH] = bank_q[e][2*PW + k];
    end
  end

endmodule

// File: tb/tb_msm_stream_loader.sv
// Self-checking bench for msm_stream_loader: random word streams and results checked
// against a word-order reference model of the load and result serialisation.
module tb_msm_stream_loader;

  localparam int unsigned LENGTH       = 2;
  localparam int unsigned P_WIDTH      = 64;
  localparam int unsigned SCALAR_WIDTH = 64;
  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned PW           = P_WIDTH / WORD_WIDTH;
  localparam int unsigned WPE          = 2 * PW + SCALAR_WIDTH / WORD_WIDTH;
  localparam int unsigned NIN          = LENGTH * WPE;
  localparam int unsigned OUTW         = 2 * PW;

  localparam logic [4:0] ST_LOAD = 5'b11000;  // {in_ready, msm_reset, out_valid, out_last, busy}
  localparam logic [4:0] ST_KICK = 5'b01001;
  localparam logic [4:0] ST_WAIT = 5'b00001;
  localparam logic [4:0] ST_SEND = 5'b00101;

  logic clk = 1'b0;
  logic Reset;
  logic [LENGTH-1:0][2*P_WIDTH-1:0]    G;
  logic [LENGTH-1:0][SCALAR_WIDTH-1:0] x;
  logic                                msm_reset;
  logic                                msm_done;
  logic [P_WIDTH-1:0]                  msm_Rx;
  logic [P_WIDTH-1:0]                  msm_Ry;
  logic                                busy;

  msm_stream_loader_if #(.WORD_WIDTH(WORD_WIDTH)) io ();

  msm_stream_loader #(
    .LENGTH(LENGTH), .P_WIDTH(P_WIDTH), .SCALAR_WIDTH(SCALAR_WIDTH), .WORD_WIDTH(WORD_WIDTH)
  ) dut (
    .clk(clk), .Reset(Reset), .io(io), .G(G), .x(x), .msm_reset(msm_reset),
    .msm_done(msm_done), .msm_Rx(msm_Rx), .msm_Ry(msm_Ry), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WORD_WIDTH-1:0] words [NIN];

  function automatic logic [4:0] status();
    return {io.in_ready, msm_reset, io.out_valid, io.out_last, busy};
  endfunction

  // Reference: field f (0=G.x, 1=G.y, 2=scalar) of element e, assembled LS word first.
  function automatic logic [63:0] model_field(int e, int f);
    logic [63:0] v = '0;
    for (int k = 0; k < PW; k++) v |= 64'(words[e*WPE + f*PW + k]) << (WORD_WIDTH * k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    Reset = 1'b1; #2; Reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < NIN; i++) words[i] = $urandom;
  endtask

  task automatic drive_load(input bit bubbles, input int count);
    int idx = 0;
    int budget = 0;
    bit phase = 1'b0;
    while (idx < count && budget < 200) begin
      io.in_valid = bubbles ? phase : 1'b1;
      phase = ~phase;
      io.in_data = io.in_valid ? words[idx] : WORD_WIDTH'($urandom);
      if (io.in_valid && io.in_ready) idx++;
      tick();
      budget++;
    end
    io.in_valid = 1'b0;
    checks++;
    if (idx != count) begin
      errors++;
      $display("FAIL load_accept: accepted %0d words, expected %0d", idx, count);
    end
  endtask

  task automatic collect_result(input int mode);
    logic [WORD_WIDTH-1:0] exp_w [OUTW];
    logic [4:0] es;
    int n = 0;
    int b = 0;
    bit tog = 1'b0;
    for (int k = 0; k < OUTW; k++)
      exp_w[k] = (k < PW) ? msm_Rx[WORD_WIDTH*k +: WORD_WIDTH] : msm_Ry[WORD_WIDTH*(k-PW) +: WORD_WIDTH];
    while (!io.out_valid && b < 50) begin tick(); b++; end
    b = 0;
    while (n < OUTW && b < 200) begin
      io.out_ready = (mode == 0) ? tog : (mode == 1) ? 1'($urandom) : 1'b1;
      tog = ~tog;
      es = ST_SEND | {3'b000, 1'(n == OUTW - 1), 1'b0};
      checks++;
      if (status() !== es || io.out_data !== exp_w[n]) begin
        errors++;
        $display("FAIL result_word%0d: status %b data %h, expected status %b data %h",
                 n, status(), io.out_data, es, exp_w[n]);
      end
      if (io.out_ready) n++;
      tick();
      b++;
    end
    io.out_ready = 1'b0;
    checks++;
    if (n != OUTW || status() !== ST_LOAD) begin
      errors++;
      $display("FAIL result_end: words %0d status %b, expected %0d status %b", n, status(), OUTW, ST_LOAD);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (status() !== ST_LOAD || io.out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: status %b data %h, expected %b data 0", status(), io.out_data, ST_LOAD);
    end
  endtask

  task automatic test_load_mapping();
    for (int i = 0; i < NIN; i++) words[i] = WORD_WIDTH'(i);
    drive_load(1'b0, NIN);
    checks++;
    if (G[0] !== {64'h00000001_00000000, 64'h00000003_00000002} || x[0] !== 64'h00000005_00000004 ||
        G[1][127:64] !== 64'h00000007_00000006) begin
      errors++;
      $display("FAIL load_map_const: G0 %h x0 %h G1 %h", G[0], x[0], G[1]);
    end
    checks++;
    if (status() !== ST_KICK) begin
      errors++;
      $display("FAIL load_kick: status %b, expected %b", status(), ST_KICK);
    end
    tick();
    checks++;
    if (status() !== ST_WAIT) begin
      errors++;
      $display("FAIL load_wait: status %b, expected %b", status(), ST_WAIT);
    end
    reset_dut();
  endtask

  task automatic test_stale_done();
    logic [4:0] exp_seq [4] = '{ST_KICK, ST_WAIT, ST_WAIT, ST_SEND};
    randomize_words();
    msm_Rx = {$urandom, $urandom};
    msm_Ry = {$urandom, $urandom};
    msm_done = 1'b1;
    drive_load(1'b0, NIN);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (status() !== exp_seq[c]) begin
        errors++;
        $display("FAIL stale_done_cyc%0d: status %b, expected %b", c, status(), exp_seq[c]);
      end
      if (c < 3) tick();
    end
    collect_result(2);
    msm_done = 1'b0;
  endtask

  task automatic test_backpressure();
    randomize_words();
    msm_Rx = 64'hAAAA0001_AAAA0000;
    msm_Ry = 64'hBBBB0001_BBBB0000;
    drive_load(1'b0, NIN);
    msm_done = 1'b1;
    collect_result(0);
    msm_done = 1'b0;
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < NIN; i++) words[i] = WORD_WIDTH'(i);
    drive_load(1'b1, NIN);
    for (int e = 0; e < LENGTH; e++) begin
      checks++;
      if (G[e] !== {model_field(e, 0), model_field(e, 1)} || x[e] !== model_field(e, 2)) begin
        errors++;
        $display("FAIL bubbles_bank%0d: G %h x %h, expected G %h x %h", e, G[e], x[e],
                 {model_field(e, 0), model_field(e, 1)}, model_field(e, 2));
      end
    end
    checks++;
    if (status() !== ST_KICK) begin
      errors++;
      $display("FAIL bubbles_kick: status %b, expected %b", status(), ST_KICK);
    end
    reset_dut();
  endtask

  task automatic test_mid_reset();
    randomize_words();
    drive_load(1'b0, 7);
    Reset = 1'b1; #1;
    checks++;
    if (status() !== ST_LOAD || io.out_data !== '0) begin
      errors++;
      $display("FAIL midload_reset: status %b data %h, expected %b data 0", status(), io.out_data, ST_LOAD);
    end
    #1 Reset = 1'b0;
    @(posedge clk); #1;
    randomize_words();
    drive_load(1'b0, NIN);
    for (int e = 0; e < LENGTH; e++) begin
      checks++;
      if (G[e] !== {model_field(e, 0), model_field(e, 1)} || x[e] !== model_field(e, 2)) begin
        errors++;
        $display("FAIL midreset_bank%0d: G %h x %h, expected G %h x %h", e, G[e], x[e],
                 {model_field(e, 0), model_field(e, 1)}, model_field(e, 2));
      end
    end
    msm_Rx = {$urandom, $urandom};
    msm_Ry = {$urandom, $urandom};
    msm_done = 1'b1;
    repeat (4) tick();
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    Reset = 1'b1; #1;
    checks++;
    if (status() !== ST_LOAD || io.out_data !== '0) begin
      errors++;
      $display("FAIL midsend_reset: status %b data %h, expected %b data 0", status(), io.out_data, ST_LOAD);
    end
    #1 Reset = 1'b0;
    msm_done = 1'b0;
    @(posedge clk); #1;
    randomize_words();
    drive_load(1'b0, NIN);
    msm_done = 1'b1;
    collect_result(2);
    msm_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int run = 0; run < 6; run++) begin
      int d = $urandom_range(0, 5);
      int k = 0;
      randomize_words();
      msm_Rx = {$urandom, $urandom};
      msm_Ry = {$urandom, $urandom};
      drive_load(1'($urandom), NIN);
      for (int e = 0; e < LENGTH; e++) begin
        checks++;
        if (G[e] !== {model_field(e, 0), model_field(e, 1)} || x[e] !== model_field(e, 2)) begin
          errors++;
          $display("FAIL b2b_bank_r%0d_e%0d: G %h x %h, expected G %h x %h", run, e, G[e], x[e],
                   {model_field(e, 0), model_field(e, 1)}, model_field(e, 2));
        end
      end
      while (!io.out_valid && k < 20) begin
        if (k == d) msm_done = 1'b1;
        tick();
        k++;
      end
      checks++;
      if (k != ((d + 1 > 3) ? d + 1 : 3)) begin
        errors++;
        $display("FAIL b2b_latency_r%0d: out_valid after %0d cycles, expected %0d", run, k,
                 (d + 1 > 3) ? d + 1 : 3);
      end
      collect_result(1);
      msm_done = 1'b0;
    end
  endtask

  initial begin
    Reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    msm_done     = 1'b0;
    msm_Rx       = '0;
    msm_Ry       = '0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_mapping();
    test_stale_done();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
